// File: rtl/qar_gpio_pkg.sv
// qar_gpio_pkg: shared widths, edge record and edge helper for the
// qar_gpio_in_cond GPIO input conditioner.
package qar_gpio_pkg;

   localparam int GPIO_WIDTH     = 32;
   localparam int DEBOUNCE_CNT_W = 8;
   localparam int PRESCALE_CNT_W = 16;

   // Edge events a pin reports on the cycle its stable level flips.
   typedef struct packed {
      logic fall;
      logic rise;
   } pin_edge_t;

   // Qualify a stable-level transition with the per-pin edge enables.
   function automatic pin_edge_t edge_detect(input logic cur, input logic nxt,
                                             input logic rise_en, input logic fall_en);
      pin_edge_t ev;
      ev.rise = ~cur & nxt & rise_en;
      ev.fall = cur & ~nxt & fall_en;
      return ev;
   endfunction

endpackage

// File: rtl/qar_gpio_in_cond_debounce_bit.sv
// qar_gpio_debounce_bit: one GPIO pin -- two-flop synchroniser, optional
// tick-driven debounce counter (macro QAR_GPIO_DEBOUNCE_EN), stable level
// and same-cycle rise/fall events for the pending logic in the top.
module qar_gpio_debounce_bit
   import qar_gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic pad,
   input  logic tick,
   input  logic rise_en,
   input  logic fall_en,
   output logic stable,
   output logic rise,
   output logic fall
);

   logic      sync_q1;
   logic      sync_q2;
   logic      stable_next;
   pin_edge_t ev;

   // Two-flop synchroniser for the asynchronous pad level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= pad;
         sync_q2 <= sync_q1;
      end
   end

`ifdef QAR_GPIO_DEBOUNCE_EN
   localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [DEBOUNCE_CNT_W-1:0] cnt_q;
   logic [DEBOUNCE_CNT_W-1:0] cnt_next;

   // Count consecutive differing ticks; flip stable on the last one, and
   // restart the count whenever the synchronised level agrees again.
   always_comb begin
      stable_next = stable;
      cnt_next    = cnt_q;
      if (tick) begin
         if (sync_q2 == stable) begin
            cnt_next = '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_next = sync_q2;
            cnt_next    = '0;
         end else begin
            cnt_next = cnt_q + 1'b1;
         end
      end
   end

   // Debounce counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_next;
      end
   end
`else
   // Without debounce the stable level just follows the synchroniser.
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
   logic unused_tick;
   assign unused_tick = tick;
   assign stable_next = sync_q2;
`endif

   // Stable (debounced) level register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= 1'b0;
      end else begin
         stable <= stable_next;
      end
   end

   // Edges are reported combinationally on the cycle stable is about to flip.
   assign ev   = edge_detect(stable, stable_next, rise_en, fall_en);
   assign rise = ev.rise;
   assign fall = ev.fall;

endmodule

// File: rtl/qar_gpio_in_cond.sv
// qar_gpio_in_cond: GPIO input conditioner in front of qar_core's gpio_in
// and irq_external. Per-pin sync/debounce/edge detect, sticky pending flags
// and a registered level interrupt. Debounce and the shared prescaler exist
// only when macro QAR_GPIO_DEBOUNCE_EN is defined.
module qar_gpio_in_cond
   import qar_gpio_pkg::*;
#(
   parameter int WIDTH           = GPIO_WIDTH,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PRESCALE        = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pad_in,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic             pend_clr,
   input  logic [WIDTH-1:0] pend_clr_mask,
   input  logic             irq_ack,
   output logic [WIDTH-1:0] gpio_clean,
   output logic [WIDTH-1:0] pending,
   output logic             irq
);

   logic             tick;
   logic [WIDTH-1:0] rise_v;
   logic [WIDTH-1:0] fall_v;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] pending_next;

`ifdef QAR_GPIO_DEBOUNCE_EN
   localparam logic [PRESCALE_CNT_W-1:0] PRE_LAST = PRESCALE_CNT_W'(PRESCALE - 1);

   logic [PRESCALE_CNT_W-1:0] pre_cnt;

   // Shared sample-tick prescaler, wrapping at PRESCALE-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);
`else
   localparam int unused_prescale = PRESCALE;
   assign tick = 1'b1;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      qar_gpio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_pin (
         .clk     (clk),
         .rst_n   (rst_n),
         .pad     (pad_in[i]),
         .tick    (tick),
         .rise_en (rise_en[i]),
         .fall_en (fall_en[i]),
         .stable  (gpio_clean[i]),
         .rise    (rise_v[i]),
         .fall    (fall_v[i])
      );
   end

   // Clear sources merge; a new edge in the same cycle wins over any clear.
   always_comb begin
      clr = '0;
      if (pend_clr) begin
         clr = pend_clr_mask;
      end
      if (irq_ack) begin
         clr = '1;
      end
      pending_next = (pending & ~clr) | rise_v | fall_v;
   end

   // Sticky pending flags; irq follows the pending register by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         irq     <= 1'b0;
      end else begin
         pending <= pending_next;
         irq     <= |(pending & irq_mask);
      end
   end

endmodule
